uart_tx_8n1: RTL and testbench

Byte-serial 8N1 UART transmitter that consumes bytes produced by the CPU store path: the MMIO store decode at address bit 31 high, `write_en`/`write_data`. It provides a physical serial TX pin alongside the JTAG UART path.
- An internal FIFO absorbs CPU store bursts.
- A baud-timed shift state machine drains the FIFO onto `tx`.
- Status outputs let firmware poll before storing.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_8n1_if.sv | 29 ++
 rtl/uart_tx_fifo.sv | 49 ++++
 rtl/uart_tx_8n1.sv | 142 ++++++++++++++
 tb/tb_uart_tx_8n1.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART transmitter.
//   tx_state_e : frame state machine encoding
//   IDLE_LVL   : line level while no frame is being sent
//   calc_div   : clocks per bit, rounded to nearest
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic IDLE_LVL = 1'b1;

  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_8n1_if.sv
// CPU-side bus of the UART transmitter: store strobe/data, overflow clear,
// serial pin and status.
//   master : CPU / store decode (drives write_en, write_data, overflow_clr)
//   slave  : transmitter (drives tx and all status)
interface uart_tx_8n1_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          write_en;
  logic [7:0]    write_data;
  logic          overflow_clr;
  logic          tx;
  logic          tx_busy;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output write_en, write_data, overflow_clr,
    input  tx, tx_busy, fifo_empty, fifo_full, fifo_count, overflow
  );

  modport slave (
    input  write_en, write_data, overflow_clr,
    output tx, tx_busy, fifo_empty, fifo_full, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the CPU store path and the transmit state machine.
//   clk, reset    : clock, async active-high reset (discards contents)
//   i_push, i_din : write strobe and byte; ignored when full
//   i_pop         : consume head; ignored when empty
//   o_dout        : head byte (valid when !o_empty)
//   o_full, o_empty, o_count : occupancy status
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_push,
  input  logic [7:0]  i_din,
  input  logic        i_pop,
  output logic [7:0]  o_dout,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count
);

  logic [7:0]  r_mem [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0] r_wptr, r_rptr;
  logic        w_push, w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  assign o_count = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter fed from CPU stores through a byte FIFO.
//   clk, reset : system clock, async active-high reset
//   bus        : uart_tx_8n1_if.slave (write_en/write_data/overflow_clr in;
//                tx, tx_busy, fifo_empty/full/count, overflow out)
// Each line bit is held DIV = round(CLK_HZ/BAUD) clocks; frames from a
// non-empty FIFO go out back to back.
module uart_tx_8n1
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_8n1_if.slave  bus
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int BW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_8n1: CLK_HZ/BAUD gives fewer than 2 clocks per bit");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_8n1: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  tx_state_e     r_state, w_state_nxt;
  logic [BW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic          r_tx, w_tx_nxt;
  logic          r_ovf;
  logic          w_tick, w_pop;
  logic [7:0]    w_head;
  logic          w_full, w_empty;
  logic [AW:0]   w_count;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.write_en),
    .i_din   (bus.write_data),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_tick = (r_cnt == BW'(DIV - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt = IDLE_LVL;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_tx_nxt    = 1'b0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_tick) begin
          w_tx_nxt    = r_shift[0];
          w_bit_nxt   = 3'd0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = STOP;
          end else begin
            // shift[0] is the bit on the line; shift[1] goes next.
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
            w_bit_nxt   = r_bit + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_tx_nxt    = 1'b0;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Restart bit timing on every state entry and at each bit boundary.
    if (r_state == IDLE || w_tick || w_state_nxt != r_state) w_cnt_nxt = '0;
    else                                                     w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_bit   <= '0;
      r_tx    <= IDLE_LVL;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Fullness is taken before any same-cycle pop; a drop beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_ovf <= 1'b0;
    else if (bus.write_en && w_full)  r_ovf <= 1'b1;
    else if (bus.overflow_clr)        r_ovf <= 1'b0;
  end

  assign bus.tx         = r_tx;
  assign bus.tx_busy    = (r_state != IDLE);
  assign bus.fifo_empty = w_empty;
  assign bus.fifo_full  = w_full;
  assign bus.fifo_count = w_count;
  assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1 at DIV=16: stimulus queues expected bytes, a line
// monitor decodes frames and compares them against the queue.
module tb_uart_tx_8n1;

  localparam int DIV = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_tx_8n1_if #(.FIFO_DEPTH(16)) u_if();

  uart_tx_8n1 #(.CLK_HZ(160), .BAUD(10), .FIFO_DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         compared   = 0;
  int         mismatched = 0;
  bit         mon_en     = 1'b0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         last_push  = 0;

  task automatic check(input string nm, input int got, input int want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int i);
    int k;
    k = i / DIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Called at a negedge; the push lands on the following posedge.
  task automatic push(input logic [7:0] d, input bit accept);
    u_if.write_en   = 1'b1;
    u_if.write_data = d;
    if (accept) exp_q.push_back(d);
    last_push = cyc + 1;
    @(negedge clk);
    u_if.write_en = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || u_if.tx_busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", int'(n < maxc), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_line_high(input string nm, input int ncyc);
    int bad;
    bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (u_if.tx !== 1'b1 || u_if.tx_busy !== 1'b0) bad++;
    end
    check(nm, bad, 0);
  endtask

  // Line monitor: one whole frame (10*DIV clocks) per detected start bit.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && u_if.tx === 1'b0) begin
        bit         have;
        logic [7:0] want;
        logic [7:0] got;
        int         bad;
        start_q.push_back(cyc);
        have = (exp_q.size() > 0);
        want = have ? exp_q.pop_front() : 8'h00;
        got  = 8'h00;
        bad  = -1;
        for (int i = 0; i < 10 * DIV; i++) begin
          if (i > 0) @(negedge clk);
          if (i % DIV == DIV / 2 && i / DIV >= 1 && i / DIV <= 8) got[i/DIV-1] = u_if.tx;
          if (have && bad < 0 && u_if.tx !== exp_bit(want, i)) bad = i;
        end
        if (!have) check("unexpected_frame", int'(got), -1);
        else begin
          check("frame_bit_timing", bad, -1);
          check("rx_byte", int'(got), int'(want));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fall;
    u_if.write_en     = 1'b0;
    u_if.write_data   = 8'h00;
    u_if.overflow_clr = 1'b0;

    // 1: reset state and idle line
    repeat (3) @(negedge clk);
    check("rst_tx", int'(u_if.tx), 1);
    check("rst_busy", int'(u_if.tx_busy), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_empty", int'(u_if.fifo_empty), 1);
    check("rst_full", int'(u_if.fifo_full), 0);
    check("rst_count", int'(u_if.fifo_count), 0);
    check("rst_ovf", int'(u_if.overflow), 0);
    check_line_high("idle_200", 200);
    mon_en = 1'b1;

    // 2: single 0x55 frame, fall latency and busy length
    start_q.delete();
    push(8'h55, 1'b1);
    n = 0;
    while (start_q.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t2_frame_seen", int'(start_q.size() > 0), 1);
    if (start_q.size() > 0) begin
      fall = start_q[0];
      check("t2_fall_latency", fall - last_push, 1);
      while (cyc < fall + 10 * DIV - 1) @(negedge clk);
      check("t2_busy_last", int'(u_if.tx_busy), 1);
      @(negedge clk);
      check("t2_busy_drop", int'(u_if.tx_busy), 0);
    end
    wait_drain(400);

    // 3: back-to-back frames
    start_q.delete();
    push(8'hA5, 1'b1);
    push(8'h3C, 1'b1);
    wait_drain(600);
    check("t3_frames", start_q.size(), 2);
    if (start_q.size() == 2) check("t3_contiguous", start_q[1] - start_q[0], 10 * DIV);

    // 4: fill to full, overflow on the 18th push
    for (int i = 0; i < 18; i++) begin
      push(8'(i), i < 17);
      if (i == 16) begin
        check("t4_count16", int'(u_if.fifo_count), 16);
        check("t4_full", int'(u_if.fifo_full), 1);
        check("t4_ovf_before", int'(u_if.overflow), 0);
      end
    end
    check("t4_ovf_set", int'(u_if.overflow), 1);
    check("t4_count_hold", int'(u_if.fifo_count), 16);

    // 6: drop and clear in the same cycle -> set wins; then clear alone
    u_if.write_en     = 1'b1;
    u_if.write_data   = 8'h99;
    u_if.overflow_clr = 1'b1;
    @(negedge clk);
    u_if.write_en = 1'b0;
    check("t6_set_wins", int'(u_if.overflow), 1);
    @(negedge clk);
    u_if.overflow_clr = 1'b0;
    check("t6_cleared", int'(u_if.overflow), 0);
    wait_drain(4000);

    // 5: async reset in the middle of data bit 3
    mon_en = 1'b0;
    push(8'hFF, 1'b0);
    n = 0;
    while (u_if.tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_start", int'(u_if.tx), 0);
    repeat (4 * DIV + DIV / 2) @(negedge clk);
    check("t5_bit3", int'(u_if.tx), 1);
    u_if.write_data = 8'h00;
    #2 reset = 1'b1;
    #1;
    check("t5_rst_tx", int'(u_if.tx), 1);
    check("t5_rst_busy", int'(u_if.tx_busy), 0);
    check("t5_rst_empty", int'(u_if.fifo_empty), 1);
    check("t5_rst_count", int'(u_if.fifo_count), 0);
    @(negedge clk);
    reset = 1'b0;
    check_line_high("t5_quiet", 200);
    mon_en = 1'b1;
    push(8'h81, 1'b1);
    wait_drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
